// File: rtl/go_pkg.sv
// Shared types and constants for the networked Go game sequencer:
// FSM states, cell colour codes, packet header/pass codes and packet field offsets.
package go_pkg;

  localparam int BOARD_W = 32'd162;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOCAL_WAIT  = 3'd1,
    ST_UPDATE      = 3'd2,
    ST_TX          = 3'd3,
    ST_REMOTE_WAIT = 3'd4,
    ST_CHECK       = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CELL_E = 2'b00,
    CELL_B = 2'b01,
    CELL_W = 2'b10
  } cell_e;

  localparam logic [7:0] PKT_HDR   = 8'hA5;
  localparam logic [7:0] PASS_MOVE = 8'hFF;

  // Frame layout, LSB offsets into the packet.
  localparam int HDR_LSB   = 32'd200;
  localparam int MOVE_LSB  = 32'd192;
  localparam int SEQ_LSB   = 32'd184;
  localparam int COLOR_BIT = 32'd183;
  localparam int PAD_LSB   = 32'd162;
  localparam int PAD_W     = 32'd21;
  localparam int BOARD_LSB = 32'd0;

  function automatic logic move_in_range(input logic [7:0] mv);
    return (mv[7:4] <= 4'd8) && (mv[3:0] <= 4'd8);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Updater and UART link signals of the game sequencer; master is the sequencer,
// slave is the board updater / UART side.
interface game_sequencer_if #(
  parameter int unsigned PKT_LEN = 32'd208
);
  logic                          upd_start_out;
  logic [7:0]                    upd_move_out;
  logic                          upd_turn_out;
  logic [go_pkg::BOARD_W-1:0]    upd_board_out;
  logic                          upd_ready_in;
  logic [go_pkg::BOARD_W-1:0]    upd_board_in;
  logic                          tx_trigger_out;
  logic [PKT_LEN-1:0]            tx_bus_out;
  logic                          rx_ready_in;
  logic [PKT_LEN-1:0]            rx_bus_in;

  modport master (
    output upd_start_out, upd_move_out, upd_turn_out, upd_board_out,
    input  upd_ready_in, upd_board_in,
    output tx_trigger_out, tx_bus_out,
    input  rx_ready_in, rx_bus_in
  );

  modport slave (
    input  upd_start_out, upd_move_out, upd_turn_out, upd_board_out,
    output upd_ready_in, upd_board_in,
    input  tx_trigger_out, tx_bus_out,
    output rx_ready_in, rx_bus_in
  );
endinterface

// File: rtl/pkt_codec.sv
// Stateless framing for the move exchange link: builds the outgoing packet
// and decides whether a received packet is the opponent's next move.
module pkt_codec
  import go_pkg::*;
#(
  parameter int unsigned PKT_LEN = 32'd208
) (
  input  logic [7:0]         move,
  input  logic [7:0]         local_seq,
  input  logic               mover_color,
  input  logic [BOARD_W-1:0] board,
  input  logic [PKT_LEN-1:0] rx_pkt,
  input  logic               player_color,
  output logic [7:0]         seq_next,
  output logic [PKT_LEN-1:0] tx_pkt,
  output logic               rx_ok,
  output logic [7:0]         rx_seq,
  output logic [BOARD_W-1:0] rx_board
);

  logic [7:0] rx_hdr_s;
  logic       rx_color_s;
  logic       unused_pad_s;

  assign seq_next = local_seq + 8'd1;

  // Outgoing frame; the pad field and any spare bits stay zero.
  always_comb begin
    tx_pkt                       = '0;
    tx_pkt[HDR_LSB +: 8]         = PKT_HDR;
    tx_pkt[MOVE_LSB +: 8]        = move;
    tx_pkt[SEQ_LSB +: 8]         = seq_next;
    tx_pkt[COLOR_BIT]            = mover_color;
    tx_pkt[BOARD_LSB +: BOARD_W] = board;
  end

  assign rx_hdr_s     = rx_pkt[HDR_LSB +: 8];
  assign rx_seq       = rx_pkt[SEQ_LSB +: 8];
  assign rx_color_s   = rx_pkt[COLOR_BIT];
  assign rx_board     = rx_pkt[BOARD_LSB +: BOARD_W];
  assign unused_pad_s = ^rx_pkt[PAD_LSB +: PAD_W];

  // The 8-bit compare makes the FF->00 wrap fall out naturally.
  assign rx_ok = (rx_hdr_s == PKT_HDR) &&
                 (rx_seq == seq_next) &&
                 (rx_color_s != player_color);

endmodule

// File: rtl/game_sequencer.sv
// Turn sequencer for a networked Go board: hands local moves to the board
// updater, frames them for the UART link and validates the opponent's packets.
module game_sequencer
  import go_pkg::*;
#(
  parameter int unsigned PKT_LEN     = 32'd208,
  parameter int unsigned UPD_TIMEOUT = 32'd4096,
  parameter int unsigned TX_HOLD     = 32'd1_500_000
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               player_color_in,
  input  logic               move_valid_in,
  input  logic [7:0]         move_in,
  game_sequencer_if.master   bus,
  output logic [BOARD_W-1:0] board_out,
  output logic               turn_out,
  output logic [2:0]         state_out,
  output logic               err_out
);

  localparam logic [31:0] UPD_LAST  = 32'(UPD_TIMEOUT - 32'd1);
  localparam logic [31:0] HOLD_LAST = 32'(TX_HOLD - 32'd1);

  state_e             state_r, state_nx_s;
  logic               player_color_r;
  logic               turn_r;
  logic [BOARD_W-1:0] board_r;
  logic [7:0]         seq_r;
  logic [7:0]         move_r;
  logic [PKT_LEN-1:0] rx_bus_r;
  logic [31:0]        timer_r;
  logic [31:0]        hold_r;
  logic               upd_start_r;
  logic [7:0]         upd_move_r;
  logic               upd_turn_r;
  logic [BOARD_W-1:0] upd_board_r;
  logic               tx_trigger_r;
  logic [PKT_LEN-1:0] tx_bus_r;
  logic               err_r;

  logic               err_nx_s;
  logic               upd_start_nx_s;
  logic               latch_color_s;
  logic               latch_move_s;
  logic               commit_upd_s;
  logic               tx_fire_s;
  logic               toggle_turn_s;
  logic               latch_rx_s;
  logic               commit_rx_s;
  logic [7:0]         seq_next_s;
  logic [PKT_LEN-1:0] tx_pkt_s;
  logic               rx_ok_s;
  logic [7:0]         rx_seq_s;
  logic [BOARD_W-1:0] rx_board_s;

  pkt_codec #(.PKT_LEN(PKT_LEN)) u_codec (
    .move         (move_r),
    .local_seq    (seq_r),
    .mover_color  (turn_r),
    .board        (board_r),
    .rx_pkt       (rx_bus_r),
    .player_color (player_color_r),
    .seq_next     (seq_next_s),
    .tx_pkt       (tx_pkt_s),
    .rx_ok        (rx_ok_s),
    .rx_seq       (rx_seq_s),
    .rx_board     (rx_board_s)
  );

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nx_s     = state_r;
    err_nx_s       = 1'b0;
    upd_start_nx_s = 1'b0;
    latch_color_s  = 1'b0;
    latch_move_s   = 1'b0;
    commit_upd_s   = 1'b0;
    tx_fire_s      = 1'b0;
    toggle_turn_s  = 1'b0;
    latch_rx_s     = 1'b0;
    commit_rx_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        latch_color_s = 1'b1;
        if (player_color_in) begin
          state_nx_s = ST_REMOTE_WAIT;
        end else begin
          state_nx_s = ST_LOCAL_WAIT;
        end
      end
      ST_LOCAL_WAIT: begin
        if (move_valid_in) begin
          // Pass must be tested first: 8'hFF is out of range as a coordinate.
          if (move_in == PASS_MOVE) begin
            latch_move_s = 1'b1;
            state_nx_s   = ST_TX;
          end else if (move_in_range(move_in)) begin
            latch_move_s   = 1'b1;
            upd_start_nx_s = 1'b1;
            state_nx_s     = ST_UPDATE;
          end else begin
            err_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_LOCAL_WAIT;
        end
      end
      ST_UPDATE: begin
        if (bus.upd_ready_in) begin
          if (bus.upd_board_in != board_r) begin
            commit_upd_s = 1'b1;
            state_nx_s   = ST_TX;
          end else begin
            err_nx_s   = 1'b1;
            state_nx_s = ST_LOCAL_WAIT;
          end
        end else if (timer_r == UPD_LAST) begin
          err_nx_s   = 1'b1;
          state_nx_s = ST_LOCAL_WAIT;
        end else begin
          state_nx_s = ST_UPDATE;
        end
      end
      ST_TX: begin
        tx_fire_s = (hold_r == 32'd0);
        if (hold_r == HOLD_LAST) begin
          toggle_turn_s = 1'b1;
          state_nx_s    = ST_REMOTE_WAIT;
        end else begin
          state_nx_s = ST_TX;
        end
      end
      ST_REMOTE_WAIT: begin
        if (bus.rx_ready_in) begin
          latch_rx_s = 1'b1;
          state_nx_s = ST_CHECK;
        end else begin
          state_nx_s = ST_REMOTE_WAIT;
        end
      end
      ST_CHECK: begin
        if (rx_ok_s) begin
          commit_rx_s   = 1'b1;
          toggle_turn_s = 1'b1;
          state_nx_s    = ST_LOCAL_WAIT;
        end else begin
          err_nx_s   = 1'b1;
          state_nx_s = ST_REMOTE_WAIT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: committed board, sequence, turn, latched packets and strobes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      player_color_r <= 1'b0;
      turn_r         <= 1'b0;
      board_r        <= '0;
      seq_r          <= 8'd0;
      move_r         <= 8'd0;
      rx_bus_r       <= '0;
      timer_r        <= 32'd0;
      hold_r         <= 32'd0;
      upd_start_r    <= 1'b0;
      upd_move_r     <= 8'd0;
      upd_turn_r     <= 1'b0;
      upd_board_r    <= '0;
      tx_trigger_r   <= 1'b0;
      tx_bus_r       <= '0;
      err_r          <= 1'b0;
    end else begin
      upd_start_r  <= upd_start_nx_s;
      tx_trigger_r <= tx_fire_s;
      err_r        <= err_nx_s;
      if (latch_color_s) begin
        player_color_r <= player_color_in;
      end
      if (latch_move_s) begin
        move_r <= move_in;
      end
      if (upd_start_nx_s) begin
        upd_move_r  <= move_in;
        upd_turn_r  <= turn_r;
        upd_board_r <= board_r;
      end
      if (commit_upd_s) begin
        board_r <= bus.upd_board_in;
      end else if (commit_rx_s) begin
        board_r <= rx_board_s;
      end
      if (tx_fire_s) begin
        tx_bus_r <= tx_pkt_s;
        seq_r    <= seq_next_s;
      end else if (commit_rx_s) begin
        seq_r <= rx_seq_s;
      end
      if (toggle_turn_s) begin
        turn_r <= ~turn_r;
      end
      if (latch_rx_s) begin
        rx_bus_r <= bus.rx_bus_in;
      end
      timer_r <= (state_r == ST_UPDATE) ? timer_r + 32'd1 : 32'd0;
      hold_r  <= (state_r == ST_TX) ? hold_r + 32'd1 : 32'd0;
    end
  end

  assign bus.upd_start_out  = upd_start_r;
  assign bus.upd_move_out   = upd_move_r;
  assign bus.upd_turn_out   = upd_turn_r;
  assign bus.upd_board_out  = upd_board_r;
  assign bus.tx_trigger_out = tx_trigger_r;
  assign bus.tx_bus_out     = tx_bus_r;
  assign board_out          = board_r;
  assign turn_out           = turn_r;
  assign state_out          = state_r;
  assign err_out            = err_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed-vector bench for game_sequencer: local moves, updater outcomes,
// remote packet validation including sequence wrap, and mid-transmit reset.
module tb_game_sequencer;

  localparam int unsigned PKT_LEN     = 208;
  localparam int unsigned UPD_TIMEOUT = 4096;
  localparam int          TX_HOLD     = 16;

  typedef logic [207:0] val_t;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         player_color_in;
  logic         move_valid_in;
  logic [7:0]   move_in;
  logic [161:0] board_out;
  logic         turn_out;
  logic [2:0]   state_out;
  logic         err_out;

  game_sequencer_if #(.PKT_LEN(PKT_LEN)) bus ();

  game_sequencer #(
    .PKT_LEN     (PKT_LEN),
    .UPD_TIMEOUT (UPD_TIMEOUT),
    .TX_HOLD     (TX_HOLD)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .player_color_in (player_color_in),
    .move_valid_in   (move_valid_in),
    .move_in         (move_in),
    .bus             (bus),
    .board_out       (board_out),
    .turn_out        (turn_out),
    .state_out       (state_out),
    .err_out         (err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int n_trig   = 0;
  int n_err    = 0;

  // Strobe counters, sampled on the inactive edge.
  always @(negedge clk_in) begin
    if (bus.upd_start_out)  n_start <= n_start + 1;
    if (bus.tx_trigger_out) n_trig  <= n_trig + 1;
    if (err_out)            n_err   <= n_err + 1;
  end

  task automatic chk_eq(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  task automatic send_move(input logic [7:0] mv);
    move_in = mv;
    move_valid_in = 1'b1;
    step(1);
    move_valid_in = 1'b0;
    move_in = 8'h00;
  endtask

  task automatic send_rx(input logic [207:0] pkt);
    bus.rx_bus_in = pkt;
    bus.rx_ready_in = 1'b1;
    step(1);
    bus.rx_ready_in = 1'b0;
  endtask

  task automatic upd_reply(input logic [161:0] brd);
    bus.upd_board_in = brd;
    bus.upd_ready_in = 1'b1;
    step(1);
    bus.upd_ready_in = 1'b0;
  endtask

  function automatic logic [207:0] mk_pkt(input logic [7:0] hdr, input logic [7:0] mv,
                                          input logic [7:0] sq, input logic col,
                                          input logic [161:0] brd);
    return {hdr, mv, sq, col, 21'd0, brd};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [161:0] b1, b2, b3;
    logic [207:0] bad [3];
    logic [7:0]   exp_seq;
    int e0, s0, t0, waited, guard;

    b1 = '0; b1[81:80] = 2'b01;
    b2 = b1; b2[1:0]   = 2'b10;
    b3 = b2; b3[3:2]   = 2'b01;

    rst_n_in = 1'b0;
    player_color_in = 1'b0;
    move_valid_in = 1'b0;
    move_in = 8'h00;
    bus.upd_ready_in = 1'b0;
    bus.upd_board_in = '0;
    bus.rx_ready_in = 1'b0;
    bus.rx_bus_in = '0;
    step(3);

    chk_eq("rst_state", val_t'(state_out), val_t'(3'd0));
    chk_eq("rst_board", val_t'(board_out), val_t'(0));
    chk_eq("rst_turn", val_t'(turn_out), val_t'(0));
    chk_eq("rst_tx_bus", val_t'(bus.tx_bus_out), val_t'(0));
    chk_eq("rst_strobes", val_t'({bus.upd_start_out, bus.tx_trigger_out, err_out, bus.upd_turn_out}), val_t'(0));
    chk_eq("rst_upd_bus", val_t'({bus.upd_move_out, bus.upd_board_out}), val_t'(0));

    rst_n_in = 1'b1;
    step(2);
    chk_eq("black_starts_local", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));
    chk_eq("black_turn0", val_t'(turn_out), val_t'(0));

    // Off-board coordinates: row 9, then column 9.
    foreach (bad[i]) bad[i] = '0;
    for (int i = 0; i < 2; i++) begin
      e0 = n_err; s0 = n_start;
      send_move(i == 0 ? 8'h9A : 8'h49);
      step(2);
      chk_eq("badmove_err", val_t'(n_err - e0), val_t'(1));
      chk_eq("badmove_nostart", val_t'(n_start - s0), val_t'(0));
      chk_eq("badmove_state", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));
    end

    // Updater hands back an unchanged board.
    e0 = n_err; s0 = n_start;
    send_move(8'h22);
    chk_eq("upd_move_22", val_t'(bus.upd_move_out), val_t'(8'h22));
    chk_eq("in_update", val_t'(state_out), val_t'(go_pkg::ST_UPDATE));
    step(2);
    upd_reply('0);
    step(2);
    chk_eq("illegal_err", val_t'(n_err - e0), val_t'(1));
    chk_eq("illegal_start_once", val_t'(n_start - s0), val_t'(1));
    chk_eq("illegal_state", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));
    chk_eq("illegal_board", val_t'(board_out), val_t'(0));

    // Updater never answers.
    e0 = n_err;
    send_move(8'h33);
    waited = 0;
    while (!err_out && waited < 5000) begin
      step(1);
      waited++;
    end
    chk_eq("timeout_cycles", val_t'(waited), val_t'(UPD_TIMEOUT));
    step(1);
    chk_eq("timeout_state", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));
    upd_reply(b1);
    step(2);
    chk_eq("late_ready_board", val_t'(board_out), val_t'(0));
    chk_eq("late_ready_state", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));
    chk_eq("timeout_err_once", val_t'(n_err - e0), val_t'(1));

    // Good move 4-4, updater answers after 10 cycles.
    s0 = n_start; t0 = n_trig;
    send_move(8'h44);
    chk_eq("start_pulse", val_t'(bus.upd_start_out), val_t'(1));
    chk_eq("upd_fields", val_t'({bus.upd_move_out, bus.upd_turn_out}), val_t'({8'h44, 1'b0}));
    step(9);
    upd_reply(b1);
    step(TX_HOLD + 4);
    chk_eq("move_one_start", val_t'(n_start - s0), val_t'(1));
    chk_eq("move_one_trig", val_t'(n_trig - t0), val_t'(1));
    chk_eq("tx_hdr_move_seq", val_t'(bus.tx_bus_out[207:184]), val_t'(24'hA5_44_01));
    chk_eq("tx_pkt_44", val_t'(bus.tx_bus_out), mk_pkt(8'hA5, 8'h44, 8'h01, 1'b0, b1));
    chk_eq("after_tx_state", val_t'(state_out), val_t'(go_pkg::ST_REMOTE_WAIT));
    chk_eq("after_tx_turn", val_t'(turn_out), val_t'(1));
    chk_eq("after_tx_board", val_t'(board_out), val_t'(b1));

    // Local move strobe while waiting for the opponent.
    e0 = n_err; s0 = n_start;
    send_move(8'h00);
    step(2);
    chk_eq("ignored_move_err", val_t'(n_err - e0), val_t'(0));
    chk_eq("ignored_move_start", val_t'(n_start - s0), val_t'(0));
    chk_eq("ignored_move_state", val_t'(state_out), val_t'(go_pkg::ST_REMOTE_WAIT));

    // Bad header, wrong seq, own colour.
    bad[0] = mk_pkt(8'h5A, 8'h00, 8'h02, 1'b1, b2);
    bad[1] = mk_pkt(8'hA5, 8'h00, 8'h03, 1'b1, b2);
    bad[2] = mk_pkt(8'hA5, 8'h00, 8'h02, 1'b0, b2);
    for (int i = 0; i < 3; i++) begin
      e0 = n_err;
      send_rx(bad[i]);
      step(2);
      chk_eq("reject_err", val_t'(n_err - e0), val_t'(1));
      chk_eq("reject_state", val_t'(state_out), val_t'(go_pkg::ST_REMOTE_WAIT));
    end
    chk_eq("reject_board", val_t'(board_out), val_t'(b1));
    chk_eq("reject_turn", val_t'(turn_out), val_t'(1));

    e0 = n_err;
    send_rx(mk_pkt(8'hA5, 8'h00, 8'h02, 1'b1, b2));
    step(2);
    chk_eq("accept_state", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));
    chk_eq("accept_turn", val_t'(turn_out), val_t'(0));
    chk_eq("accept_board", val_t'(board_out), val_t'(b2));

    // Packet strobe in LOCAL_WAIT has no effect.
    send_rx(mk_pkt(8'hA5, 8'h00, 8'h03, 1'b1, b1));
    step(2);
    chk_eq("ignored_rx_state", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));
    chk_eq("ignored_rx_board", val_t'(board_out), val_t'(b2));
    chk_eq("ignored_rx_err", val_t'(n_err - e0), val_t'(0));

    // Exchange passes until the local side has sent seq FF.
    exp_seq = 8'h02;
    guard = 0;
    t0 = n_trig;
    while (exp_seq != 8'hFF && guard < 300) begin
      send_move(8'hFF);
      step(TX_HOLD + 4);
      exp_seq = exp_seq + 8'd1;
      if (exp_seq != 8'hFF) begin
        send_rx(mk_pkt(8'hA5, 8'h00, exp_seq + 8'd1, 1'b1, b2));
        step(2);
        exp_seq = exp_seq + 8'd1;
      end
      guard++;
    end
    chk_eq("pass_trig_count", val_t'(n_trig - t0), val_t'(127));
    chk_eq("pass_pkt_ff", val_t'(bus.tx_bus_out), mk_pkt(8'hA5, 8'hFF, 8'hFF, 1'b0, b2));
    chk_eq("pass_state", val_t'(state_out), val_t'(go_pkg::ST_REMOTE_WAIT));
    chk_eq("pass_turn", val_t'(turn_out), val_t'(1));

    // Sequence wrap FF -> 00.
    e0 = n_err;
    send_rx(mk_pkt(8'h5A, 8'h00, 8'h00, 1'b1, b3));
    step(2);
    chk_eq("wrap_badhdr_err", val_t'(n_err - e0), val_t'(1));
    chk_eq("wrap_badhdr_state", val_t'(state_out), val_t'(go_pkg::ST_REMOTE_WAIT));
    send_rx(mk_pkt(8'hA5, 8'h00, 8'h00, 1'b1, b3));
    step(2);
    chk_eq("wrap_accept_state", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));
    chk_eq("wrap_accept_turn", val_t'(turn_out), val_t'(0));
    chk_eq("wrap_accept_board", val_t'(board_out), val_t'(b3));
    chk_eq("wrap_no_extra_err", val_t'(n_err - e0), val_t'(1));

    t0 = n_trig;
    send_move(8'hFF);
    step(3);
    chk_eq("wrap_next_pkt", val_t'(bus.tx_bus_out), mk_pkt(8'hA5, 8'hFF, 8'h01, 1'b0, b3));
    chk_eq("wrap_next_trig", val_t'(n_trig - t0), val_t'(1));

    // Reset in the middle of the transmit hold.
    rst_n_in = 1'b0;
    step(2);
    chk_eq("midrst_state", val_t'(state_out), val_t'(go_pkg::ST_IDLE));
    chk_eq("midrst_board", val_t'(board_out), val_t'(0));
    chk_eq("midrst_turn", val_t'(turn_out), val_t'(0));
    chk_eq("midrst_tx_bus", val_t'(bus.tx_bus_out), val_t'(0));
    rst_n_in = 1'b1;
    step(TX_HOLD + 8);
    chk_eq("midrst_no_trig", val_t'(n_trig - t0), val_t'(1));
    chk_eq("midrst_restart", val_t'(state_out), val_t'(go_pkg::ST_LOCAL_WAIT));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
